seq_multiplier: RTL and testbench

//  Sequential radix-2 shift-add multiplier; the multiply counterpart of the FPU's sequential divider.

---
 rtl/fpu_mul_pkg.sv | 18 +
 rtl/mul_add_shift_step.sv | 43 ++++
 rtl/seq_multiplier.sv | 111 +++++++++++
 tb/tb_seq_multiplier.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fpu_mul_pkg.sv
// Shared types and constants for the FPU sequential multiplier.
// Used by seq_multiplier and mul_add_shift_step (signed mode via FPU_MUL_SIGNED_EN).
package fpu_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    localparam int MUL_WIDTH = 30;

    // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mul_add_shift_step.sv
// One combinational shift-add iteration of the sequential multiplier.
// FPU_MUL_SIGNED_EN selects radix-2 Booth recoding with an arithmetic shift.
module mul_add_shift_step
    import fpu_mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] mlr,
    input  logic [WIDTH-1:0] mcand,
`ifdef FPU_MUL_SIGNED_EN
    input  logic             prev,
`endif
    output logic [WIDTH:0]   acc_next,
    output logic [WIDTH-1:0] mlr_next
);

    logic [WIDTH:0] mcand_ext;
    logic [WIDTH:0] sum;

`ifdef FPU_MUL_SIGNED_EN
    // Booth pair {mlr[0], prev}: 01 adds, 10 subtracts, 00/11 leave acc alone.
    always_comb begin
        mcand_ext = {mcand[WIDTH-1], mcand};
        sum       = acc;
        case ({mlr[0], prev})
            2'b01:   sum = acc + mcand_ext;
            2'b10:   sum = acc - mcand_ext;
            default: sum = acc;
        endcase
        acc_next = {sum[WIDTH], sum[WIDTH:1]};
        mlr_next = {sum[0], mlr[WIDTH-1:1]};
    end
`else
    always_comb begin
        mcand_ext = {1'b0, mcand};
        sum       = mlr[0] ? (acc + mcand_ext) : acc;
        acc_next  = {1'b0, sum[WIDTH:1]};
        mlr_next  = {sum[0], mlr[WIDTH-1:1]};
    end
`endif

endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 sequential multiplier: WIDTH iterations per product, start/busy/done handshake.
// Define FPU_MUL_SIGNED_EN for two's-complement (Booth) operands; default is unsigned.
module seq_multiplier
    import fpu_mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [2*WIDTH-1:0] P,
    output logic               busy,
    output logic               done
);

    localparam int CNT_W = cnt_width(WIDTH);

    mul_state_t       state;
    mul_state_t       state_next;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] mlr;
    logic [CNT_W-1:0] counter;
    logic [WIDTH:0]   acc_next;
    logic [WIDTH-1:0] mlr_next;
    logic             accept;
    logic             last_iter;

    assign accept    = start && (state == IDLE || state == DONE);
    assign last_iter = (state == RUN) && (counter == CNT_W'(1));

`ifdef FPU_MUL_SIGNED_EN
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= 1'b0;
        end else if (accept) begin
            prev <= 1'b0;
        end else if (state == RUN) begin
            prev <= mlr[0];
        end
    end

    mul_add_shift_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .mlr      (mlr),
        .mcand    (mcand),
        .prev     (prev),
        .acc_next (acc_next),
        .mlr_next (mlr_next)
    );
`else
    mul_add_shift_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .mlr      (mlr),
        .mcand    (mcand),
        .acc_next (acc_next),
        .mlr_next (mlr_next)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_iter) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // P is written only on the final iteration so it holds through DONE and IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand   <= '0;
            acc     <= '0;
            mlr     <= '0;
            counter <= '0;
            P       <= '0;
        end else if (accept) begin
            mcand   <= A;
            acc     <= '0;
            mlr     <= B;
            counter <= CNT_W'(WIDTH);
        end else if (state == RUN) begin
            acc     <= acc_next;
            mlr     <= mlr_next;
            counter <= counter - CNT_W'(1);
            if (last_iter) begin
                P <= {acc_next[WIDTH-1:0], mlr_next};
            end
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed vectors plus a cycle-level reference model.
// Signed vectors are used when FPU_MUL_SIGNED_EN is defined.
module tb_seq_multiplier;

    localparam int W = 30;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   a_in = '0;
    logic [W-1:0]   b_in = '0;
    logic [2*W-1:0] p_out;
    logic           busy;
    logic           done;

    int tests = 0;
    int fails = 0;
    bit checking = 1'b0;

    // Reference model: ops in flight counted down in cycles, product from plain arithmetic.
    int             run_left = 0;
    logic           m_done = 1'b0;
    logic [2*W-1:0] m_p = '0;
    logic [2*W-1:0] pending = '0;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (a_in),
        .B     (b_in),
        .P     (p_out),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] model_product(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] full;
`ifdef FPU_MUL_SIGNED_EN
        longint sa;
        longint sb;
        sa   = longint'({{(64-W){a[W-1]}}, a});
        sb   = longint'({{(64-W){b[W-1]}}, b});
        full = 64'(sa * sb);
`else
        full = {{(64-W){1'b0}}, a} * {{(64-W){1'b0}}, b};
`endif
        return full[2*W-1:0];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            run_left <= 0;
            m_done   <= 1'b0;
            m_p      <= '0;
        end else if (run_left > 0) begin
            run_left <= run_left - 1;
            m_done   <= (run_left == 1);
            if (run_left == 1) m_p <= pending;
        end else if (start) begin
            run_left <= W;
            m_done   <= 1'b0;
            pending  <= model_product(a_in, b_in);
        end else begin
            m_done <= 1'b0;
        end
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    always begin
        @(negedge clk);
        #1;
        if (checking) begin
            check_output("model_busy", 64'(busy), 64'(run_left > 0));
            check_output("model_done", 64'(done), 64'(m_done));
            check_output("model_P", 64'(p_out), 64'(m_p));
        end
    end

    task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        if (done !== 1'b1) begin
            check_output("done_timeout", 64'(done), 64'd1);
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] expected);
        int c;
        apply_stimulus(a, b);
        wait_done(c);
        check_output({name, "_latency"}, 64'(c), 64'(W));
        check_output({name, "_P"}, 64'(p_out), 64'(expected));
    endtask

    initial begin
        int  c;
        bit  saw_done;
        logic [W-1:0] va [3];
        logic [W-1:0] vb [3];

        va[0] = 30'h2AAAAAAA; vb[0] = 30'h15555555;
        va[1] = 30'h00000001; vb[1] = 30'h3FFFFFFF;
        va[2] = 30'h20000000; vb[2] = 30'h00000002;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        checking = 1'b1;
        @(negedge clk);
        check_output("reset_P", 64'(p_out), 64'd0);
        check_output("reset_busy", 64'(busy), 64'd0);
        check_output("reset_done", 64'(done), 64'd0);

        apply_stimulus(30'd3, 30'd5);
        check_output("basic_busy_after_accept", 64'(busy), 64'd1);
        wait_done(c);
        check_output("basic_latency", 64'(c), 64'd30);
        check_output("basic_P", 64'(p_out), 64'd15);
        @(negedge clk);
        check_output("basic_done_one_cycle", 64'(done), 64'd0);
        check_output("basic_busy_clear", 64'(busy), 64'd0);
        check_output("basic_P_held", 64'(p_out), 64'd15);

        run_op("zero", 30'h12345, 30'd0, 60'd0);

`ifdef FPU_MUL_SIGNED_EN
        run_op("neg_one_times_5", 30'h3FFFFFFF, 30'd5, 60'hFFFFFFFFFFFFFFB);
        run_op("most_negative", 30'h20000000, 30'h20000000, 60'h400000000000000);
`else
        run_op("max", 30'h3FFFFFFF, 30'h3FFFFFFF, 60'hFFFFFFF80000001);
`endif

        for (int i = 0; i < 3; i++) begin
            run_op("table", va[i], vb[i], model_product(va[i], vb[i]));
        end

        // start asserted mid-run must not disturb the in-flight operation
        apply_stimulus(30'd7, 30'd9);
        repeat (9) @(negedge clk);
        a_in  = 30'd1;
        b_in  = 30'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(c);
        check_output("ignored_start_P", 64'(p_out), 64'd63);
        @(negedge clk);
        check_output("ignored_start_idle", 64'(busy), 64'd0);

        // reset in the middle of a run abandons it without a done pulse
        apply_stimulus(30'd11, 30'd13);
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("midreset_P", 64'(p_out), 64'd0);
        check_output("midreset_busy", 64'(busy), 64'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        check_output("midreset_no_done", 64'(saw_done), 64'd0);
        run_op("after_reset", 30'd2, 30'd4, 60'd8);

        // start held high gives back-to-back operations with no idle cycle
        @(negedge clk);
        a_in  = 30'd6;
        b_in  = 30'd7;
        start = 1'b1;
        @(negedge clk);
        wait_done(c);
        check_output("b2b_first_P", 64'(p_out), 64'd42);
        @(negedge clk);
        check_output("b2b_no_gap_busy", 64'(busy), 64'd1);
        check_output("b2b_done_dropped", 64'(done), 64'd0);
        wait_done(c);
        check_output("b2b_period", 64'(c + 1), 64'd31);
        check_output("b2b_second_P", 64'(p_out), 64'd42);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_output("b2b_stopped", 64'(busy), 64'd0);

        checking = 1'b0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
